uart_tx_sequencer: RTL and testbench
====================================

// Module: uart_tx_sequencer
// PURPOSE
//  Frame sequencer for the UART transmit path. It consumes the en_tx oversample tick produced by the
//  baud divisor and accepts bytes over a valid/ready handshake. It serialises each byte as
//  start / data (LSB first) / optional parity / stop bits on txd, one bit per OVERSAMPLE ticks.
//  It sits between the CPU-side UART register interface and the txd pin.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8)
//  OVERSAMPLE  16  en_tx ticks per bit period (2..16; tick counter is 4 bits)
//  STOP_BITS   1   number of stop bits (1 or 2)
// PORTS
//  clk         in   1          UART clock
//  rst         in   1          synchronous reset, active high
//  en_tx       in   1          divisor tick, 1-clk pulse per oversample period
//  tx_data     in   DATA_BITS  byte to send, sampled on accept
//  tx_valid    in   1          tx_data valid
//  tx_ready    out  1          sequencer can accept a byte
//  parity_en   in   1          1 = insert parity bit, sampled on accept
//  parity_odd  in   1          1 = odd parity, 0 = even; sampled on accept
//  txd         out  1          serial line, idle high, registered
//  busy        out  1          frame in progress
//  frame_done  out  1          1-clk pulse after last stop bit completes
// BEHAVIOUR
//  Reset (rst high at posedge): state=IDLE, txd=1, busy=0, frame_done=0, tick_cnt=0, bit_cnt=0.
//   tx_ready=0 while rst is high; tx_ready=1 from the first cycle after rst deasserts.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: tx_ready=1, txd=1. On tx_valid&tx_ready: latch tx_data, parity_en and parity_odd.
//   Compute par = ^data ^ parity_odd. Go to START and clear tick_cnt.
//   txd=0 and busy=1 from the next cycle; tx_ready=0 from the next cycle.
//  Bit timing: tick_cnt increments on each en_tx; a bit ends on the en_tx pulse where
//   tick_cnt==OVERSAMPLE-1. tick_cnt wraps to 0 and the next bit value appears on txd the following cycle.
//   An en_tx in the accept cycle is ignored. The start bit therefore lasts exactly OVERSAMPLE ticks
//   counted after accept.
//  DATA: txd=data[bit_cnt], bit_cnt 0..DATA_BITS-1. After the last bit, go to PARITY if parity_en
//   was latched, else to STOP.
//  PARITY: txd=par for one bit period.
//  STOP: txd=1 for STOP_BITS bit periods. On the final tick: state=IDLE, busy=0, and frame_done=1
//   for exactly one cycle, concurrent with tx_ready returning to 1.
//  Back-to-back: a tx_valid already high is accepted in the cycle frame_done is high. The line never
//   drops below STOP_BITS full stop periods.
//  Changes on tx_data/parity_en/parity_odd while busy have no effect on the frame in flight.
//  tx_valid while busy is not accepted and is not lost: the source holds it per the handshake.
//  No en_tx pulses: the FSM holds its state indefinitely and txd is held.
//  Reset mid-frame: at the rst posedge, return to IDLE and drive txd=1. The partial frame is
//   abandoned and no frame_done is issued.
//  Illegal STOP_BITS is treated as 1. Unused state encodings recover to IDLE with txd=1.
// TESTING
//  1. rst high 3 cycles, en_tx free-running -> txd=1, busy=0, tx_ready=0 during reset;
//     tx_ready=1 the cycle after rst drops.
//  2. en_tx every 4 clk, parity_en=0, send 0x55 -> txd=0,1,0,1,0,1,0,1,0,1, each held 64 clk.
//     frame_done pulses once 640 clk after accept; tx_ready=0 throughout the frame.
//  3. parity_en=1: 0x07 even -> parity bit 1; 0x07 odd -> 0; 0x00 even -> 0. Frame is 11 bits long.
//  4. STOP_BITS=2, send 0xA3 -> stop high for 2*OVERSAMPLE ticks before frame_done.
//     An LSB-first decode of txd equals 0xA3.
//  5. tx_valid held high, tx_data=0x12 then 0x34, tx_data toggled randomly mid-frame -> both frames
//     decode as 0x12, 0x34; the second accept coincides with the frame_done cycle.
//  6. rst pulsed at DATA bit 3 -> txd=1 the next cycle, busy=0, no frame_done.
//     A new send of 0x81 after reset decodes correctly.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//
// Frame sequencer for the UART transmit path. Accepts one byte at a time over
// a valid/ready handshake and shifts it out on txd as start bit, data bits
// (LSB first), optional parity bit and one or two stop bits. Each bit lasts
// OVERSAMPLE pulses of en_tx, the oversample tick from the baud divisor.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   OVERSAMPLE  en_tx ticks per bit period (2..16)
//   STOP_BITS   stop bits per frame (1 or 2; any other value acts as 1)
//
// Ports
//   clk         UART clock
//   rst         synchronous reset, active high
//   en_tx       oversample tick, one clk wide
//   tx_data     byte to send, captured on accept
//   tx_valid    tx_data valid
//   tx_ready    sequencer can accept a byte (registered)
//   parity_en   insert a parity bit, captured on accept
//   parity_odd  1 = odd parity, 0 = even, captured on accept
//   txd         serial line, idles high (registered)
//   busy        a frame is in progress (registered)
//   frame_done  one-clk pulse once the last stop bit has completed

module uart_tx_sequencer #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic                 txd,
   output logic                 busy,
   output logic                 frame_done
);

   // Anything other than two stop bits falls back to a single stop bit.
   localparam int         STOP_N    = (STOP_BITS == 2) ? 2 : 1;
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_N - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t               state;
   logic [3:0]           tick_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] data_q;
   logic                 par_en_q;
   logic                 par_q;
   logic                 bit_end;

   // A bit period closes on the en_tx pulse that sees the last tick count.
   assign bit_end = en_tx && (tick_cnt == TICK_LAST);

   // Frame state machine. Every output is registered, so a decision taken on
   // a clock edge becomes visible on txd/busy/tx_ready/frame_done right after
   // that edge. The data byte is kept in a shift register so the bit on its
   // way out is always at position 0 (next one at position 1).
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         txd        <= 1'b1;
         busy       <= 1'b0;
         tx_ready   <= 1'b0;
         frame_done <= 1'b0;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (state != IDLE && en_tx)
            tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;

         case (state)
            IDLE: begin
               txd      <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
               tick_cnt <= '0;
               bit_cnt  <= '0;
               // An en_tx in the accept cycle is ignored: tick_cnt restarts
               // from zero, so the start bit gets a full OVERSAMPLE ticks.
               if (tx_valid && tx_ready) begin
                  data_q   <= tx_data;
                  par_en_q <= parity_en;
                  par_q    <= (^tx_data) ^ parity_odd;
                  state    <= START;
                  txd      <= 1'b0;
                  busy     <= 1'b1;
                  tx_ready <= 1'b0;
               end
            end

            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  txd     <= data_q[0];
               end
            end

            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        state <= PARITY;
                        txd   <= par_q;
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     data_q  <= data_q >> 1;
                     txd     <= data_q[1];
                  end
               end
            end

            PARITY: begin
               if (bit_end) begin
                  state   <= STOP;
                  bit_cnt <= '0;
                  txd     <= 1'b1;
               end
            end

            STOP: begin
               txd <= 1'b1;
               if (bit_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     tx_ready   <= 1'b1;
                     frame_done <= 1'b1;
                     bit_cnt    <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               txd      <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b0;
               tick_cnt <= '0;
               bit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer. Two instances share clock, reset, en_tx
// and the data/parity inputs: dut1 uses one stop bit, dut2 uses two. sel2
// picks which instance gets tx_valid and which outputs are observed.

module tb_uart_tx_sequencer;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_tx = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       vld = 1'b0;
   logic       sel2 = 1'b0;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;

   logic tx_valid1, tx_valid2;
   logic tx_ready1, txd1, busy1, done1;
   logic tx_ready2, txd2, busy2, done2;
   logic cur_ready, cur_txd, cur_busy, cur_done;

   int tests = 0;
   int failed = 0;
   int en_mode = 1;
   int en_cnt = 0;

   assign tx_valid1 = vld & ~sel2;
   assign tx_valid2 = vld & sel2;
   assign cur_ready = sel2 ? tx_ready2 : tx_ready1;
   assign cur_txd   = sel2 ? txd2 : txd1;
   assign cur_busy  = sel2 ? busy2 : busy1;
   assign cur_done  = sel2 ? done2 : done1;

   always #5 clk = ~clk;

   uart_tx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .en_tx(en_tx), .tx_data(tx_data),
      .tx_valid(tx_valid1), .tx_ready(tx_ready1), .parity_en(parity_en),
      .parity_odd(parity_odd), .txd(txd1), .busy(busy1), .frame_done(done1)
   );

   uart_tx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .en_tx(en_tx), .tx_data(tx_data),
      .tx_valid(tx_valid2), .tx_ready(tx_ready2), .parity_en(parity_en),
      .parity_odd(parity_odd), .txd(txd2), .busy(busy2), .frame_done(done2)
   );

   // en_tx source: 0 = off, N = one pulse every N clocks, 255 = random.
   initial begin
      forever begin
         @(negedge clk);
         if (en_mode == 0) begin
            en_tx = 1'b0;
         end else if (en_mode == 255) begin
            en_tx = 1'($urandom_range(0, 1));
         end else begin
            en_cnt = (en_cnt + 1) % en_mode;
            en_tx  = (en_cnt == 0);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sends one frame on the selected instance and follows it to frame_done.
   // Reference: the frame is a list of bits built from the rules (start 0,
   // data LSB first, optional parity, stop 1s); the expected txd at any time
   // is bit[ticks / OS], where ticks counts en_tx pulses after the accept edge.
   // Called and returns on a negedge.
   task automatic applyStimulus(input logic [7:0] d, input logic pe,
                                input logic po, input int stopn,
                                input bit keep_valid, input bit toggle,
                                input logic [7:0] next_d,
                                output int wait_cyc, output int frame_clk,
                                output logic [7:0] dec, output logic par_obs,
                                output int nb);
      logic       bits[16];
      logic       obs[16];
      bit         samp[16];
      int         ticks;
      bit         done_seen;
      bit         badset;
      logic [3:0] bad_a, bad_e;

      nb = 0;
      bits[nb++] = 1'b0;
      for (int i = 0; i < 8; i++) bits[nb++] = d[i];
      if (pe) bits[nb++] = (^d) ^ po;
      for (int s = 0; s < stopn; s++) bits[nb++] = 1'b1;
      for (int i = 0; i < 16; i++) begin obs[i] = 1'b0; samp[i] = 1'b0; end

      tx_data = d; parity_en = pe; parity_odd = po; vld = 1'b1;
      dec = 8'h00; par_obs = 1'b0; frame_clk = 0;
      wait_cyc = 0;
      while (cur_ready !== 1'b1 && wait_cyc < 2000) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (cur_ready !== 1'b1) begin
         checkOutput("accept timeout", 32'(cur_ready), 32'd1);
         vld = 1'b0;
         return;
      end

      @(posedge clk);
      @(negedge clk);
      ticks = 0; done_seen = 0; badset = 0; bad_a = '0; bad_e = '0;
      for (int c = 0; c < 8000 && !done_seen; c++) begin
         if (c > 0) begin
            @(posedge clk);
            if (en_tx) ticks++;
            @(negedge clk);
         end
         if (c == 0 && !keep_valid) vld = 1'b0;
         if (toggle) begin
            if (ticks >= (nb - 1) * OS) begin
               tx_data = next_d; parity_en = 1'b0; parity_odd = 1'b0;
            end else begin
               tx_data = 8'($urandom);
               parity_en = 1'($urandom); parity_odd = 1'($urandom);
            end
         end
         if (ticks < nb * OS) begin
            if (!badset && {cur_txd, cur_busy, cur_ready, cur_done} !==
                           {bits[ticks / OS], 3'b100}) begin
               badset = 1;
               bad_a  = {cur_txd, cur_busy, cur_ready, cur_done};
               bad_e  = {bits[ticks / OS], 3'b100};
            end
            if (ticks % OS == OS / 2 && !samp[ticks / OS]) begin
               samp[ticks / OS] = 1'b1;
               obs[ticks / OS]  = cur_txd;
            end
         end else begin
            done_seen = 1;
            frame_clk = c;
            checkOutput("end of frame {txd,busy,ready,done}",
                        32'({cur_txd, cur_busy, cur_ready, cur_done}), 32'hB);
         end
      end
      if (!done_seen) checkOutput("frame timeout", 32'd0, 32'd1);
      checkOutput("in-frame {txd,busy,ready,done}", 32'(bad_a), 32'(bad_e));
      for (int i = 0; i < 8; i++) dec[i] = obs[1 + i];
      par_obs = pe ? obs[9] : 1'b0;
      checkOutput("decoded data", 32'(dec), 32'(d));
   endtask

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       po;
      logic       exp_par;
      int         exp_bits;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int         w, fclk, nbits, cnt;
      logic [7:0] dec, rd;
      logic       pobs, rpe, rpo;

      vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 10};
      vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 11};
      vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 11};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 11};

      // Reset with en_tx free-running.
      en_mode = 1;
      rst = 1'b1;
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset {txd,busy,ready,done}",
                     32'({txd1, busy1, tx_ready1, done1}), 32'h8);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready after reset dut1", 32'(tx_ready1), 32'd1);
      checkOutput("ready after reset dut2", 32'(tx_ready2), 32'd1);

      // Table-driven frames, en_tx every 4 clk.
      en_mode = 4;
      sel2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].data, vecs[i].pe, vecs[i].po, 1, 0, 0, 8'h00,
                       w, fclk, dec, pobs, nbits);
         checkOutput("frame bit count", 32'(nbits), 32'(vecs[i].exp_bits));
         if (vecs[i].pe) checkOutput("parity bit", 32'(pobs), 32'(vecs[i].exp_par));
         if (i == 0)
            checkOutput("frame length 637..640 clk",
                        32'(fclk >= 637 && fclk <= 640), 32'd1);
      end

      // Two stop bits on dut2.
      sel2 = 1'b1;
      applyStimulus(8'hA3, 1'b0, 1'b0, 2, 0, 0, 8'h00, w, fclk, dec, pobs, nbits);
      checkOutput("two-stop bit count", 32'(nbits), 32'd11);
      sel2 = 1'b0;

      // Back-to-back with tx_valid held and tx_data churning mid-frame.
      en_mode = 3;
      applyStimulus(8'h12, 1'b0, 1'b0, 1, 1, 1, 8'h34, w, fclk, dec, pobs, nbits);
      applyStimulus(8'h34, 1'b0, 1'b0, 1, 0, 1, 8'h00, w, fclk, dec, pobs, nbits);
      checkOutput("second accept on frame_done cycle", 32'(w), 32'd0);

      // Reset during data bit 3.
      en_mode = 4;
      tx_data = 8'hFF; vld = 1'b1;
      cnt = 0;
      while (tx_ready1 !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
      @(posedge clk);
      @(negedge clk);
      vld = 1'b0;
      repeat (280) @(negedge clk);
      checkOutput("busy before abort", 32'(busy1), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort {txd,busy,ready,done}",
                  32'({txd1, busy1, tx_ready1, done1}), 32'h8);
      rst = 1'b0;
      cnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (done1 !== 1'b0 || txd1 !== 1'b1 || busy1 !== 1'b0) cnt++;
      end
      checkOutput("quiet line after abort", 32'(cnt), 32'd0);
      applyStimulus(8'h81, 1'b0, 1'b0, 1, 0, 0, 8'h00, w, fclk, dec, pobs, nbits);

      // Randomized frames with random en_tx pacing and churning inputs.
      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 3))
            0:       en_mode = 1;
            1:       en_mode = 2;
            2:       en_mode = 4;
            default: en_mode = 255;
         endcase
         rd  = 8'($urandom);
         rpe = 1'($urandom);
         rpo = 1'($urandom);
         applyStimulus(rd, rpe, rpo, 1, 0, 1, 8'($urandom), w, fclk, dec, pobs, nbits);
         if (rpe) checkOutput("random parity bit", 32'(pobs), 32'((^rd) ^ rpo));
         @(negedge clk);
         checkOutput("frame_done single pulse", 32'(done1), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
